temporal_encoder: RTL
=====================

Name: temporal_encoder

Overview:
- Converts binary values into pulse-width temporal spikes for the race-logic operators (equal, min/max and similar), which consume spikes.
- Owns the gamma-cycle timebase: generates the per-gamma grst that downstream operators use, and emits one spike per gamma cycle on a single output line.
- Values arrive over a valid/ready handshake. A value accepted in gamma k is emitted in gamma k+1.

Parameters:
GAMMA_CYCLE_WIDTH, 16, aclk cycles per gamma cycle; must be >= 3.
PULSE_WIDTH, 8, spike length in aclk cycles; must be >= 1.
VAL_W, $clog2(GAMMA_CYCLE_WIDTH), width of the value and gamma-counter buses (derived; do not override).

Ports:
aclk  in  1  clock; all state changes on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  source presents a value
in_null  in  1  with in_valid: request an empty gamma (no spike)
in_value  in  VAL_W  spike time; meaningful when in_null=0
in_ready  out  1  encoder can accept a value this cycle
grst  out  1  gamma reset to downstream; high exactly while gamma_cnt==0
y  out  1  temporal spike output
gamma_cnt  out  VAL_W  current slot within the gamma cycle, 0..GAMMA_CYCLE_WIDTH-1

Behaviour:
- State:
  - gamma counter gcnt.
  - pending register: pend_valid, pend_null, pend_val.
  - active register: act_valid, act_val.
- Reset: rst_n low clears all state immediately, independent of aclk. gcnt=0, pend_valid=0, act_valid=0. Outputs during and right after reset: grst=1, y=0, gamma_cnt=0, in_ready=1. The source must not assert in_valid while rst_n is low.
- Reset mid-spike: y drops in the same instant. The pending value is discarded. After release, the first gamma starts at gcnt=0 with no spike.
- Gamma counter:
  - gcnt increments every edge after reset release.
  - It wraps from GAMMA_CYCLE_WIDTH-1 to 0; the edge where gcnt==GAMMA_CYCLE_WIDTH-1 is the "boundary edge".
  - grst = (gcnt==0), decoded from the registered count. Period is GAMMA_CYCLE_WIDTH cycles, width 1 cycle.
- Handshake:
  - in_ready = !pend_valid.
  - Transfer occurs on an edge where in_valid && in_ready.
  - On transfer, pend loads in_null/in_value and pend_valid=1.
  - The source must hold in_valid/in_null/in_value stable until the transfer.
- Boundary edge:
  - If pend_valid: act_valid = !pend_null && (pend_val <= GAMMA_CYCLE_WIDTH-2), act_val = pend_val, then pend_valid=0.
  - Else if a transfer occurs on this same edge: bypass, so the incoming value loads act_* directly using the same rule, and pend stays empty.
  - Else: act_valid=0 (empty gamma).
- Simultaneous transfer and boundary with pend already full cannot occur, because in_ready=0.
- Spike:
  - y = act_valid && (gcnt >= act_val+1) && (gcnt <= act_val+PULSE_WIDTH), decoded from registered state only; there is no combinational path from the in_* inputs.
  - The comparison is done at VAL_W+1 bits or wider so that act_val+PULSE_WIDTH does not overflow.
  - Slot 0 (grst high) never carries a spike.
  - A spike that would run past GAMMA_CYCLE_WIDTH-1 is truncated, and y is low at the next gcnt=0.
  - Values >= GAMMA_CYCLE_WIDTH-1 produce no spike and raise no error.
- Throughput: one value per gamma cycle. A second value offered in the same gamma stalls (in_ready=0) until the boundary edge empties pend.

Test Plan (GAMMA_CYCLE_WIDTH=16, PULSE_WIDTH=8):
1. Reset:
   - Release rst_n -> grst=1 at gcnt 0, 16, 32…, width 1 cycle; y=0 for the whole first gamma; in_ready=1.
   - Assert rst_n low at gcnt=5 during a spike -> y=0, grst=1, gamma_cnt=0 immediately without a clock edge.
2. Basic spike: accept value 1 at gcnt=4 of gamma 0 -> in gamma 1, y=1 exactly at gcnt 2..9 (8 cycles) and 0 elsewhere; in_ready returns to 1 after the boundary edge.
3. Truncation and null:
   - Value 10 -> y=1 at gcnt 11..15 only (5 cycles) and y=0 at the next gcnt=0.
   - Value 15 -> no spike.
   - in_null=1 -> no spike.
   - A gamma with nothing accepted -> no spike.
4. Back-pressure: offer 3 at gcnt=2, then hold 5 on in_valid -> 3 is accepted; in_ready=0 until the boundary edge; 5 is accepted at gcnt=0 of the next gamma. Emitted spikes: gamma k+1 at gcnt 4..11, gamma k+2 at gcnt 6..13.
5. Boundary bypass:
   - With pend empty, transfer value 0 on the gcnt==15 edge -> spike at gcnt 1..8 of the very next gamma.
   - With pend full at gcnt 15 -> in_ready=0 and no transfer.
6. Streaming: random values 0..15 offered continuously with random in_null over 50 gammas -> exactly one value accepted per gamma. A scoreboard checks y per slot against the rule in Behaviour, using gamma_cnt as reference.

Source files
------------

// File: rtl/temporal_encoder.sv
// Binary-to-temporal spike encoder: owns the gamma timebase (grst) and emits one
// pulse-width spike per gamma, delayed by the value accepted in the previous gamma.
module temporal_encoder #(
  parameter int unsigned GAMMA_CYCLE_WIDTH = 16,
  parameter int unsigned PULSE_WIDTH       = 8,
  parameter int unsigned VAL_W             = $clog2(GAMMA_CYCLE_WIDTH)
) (
  input  logic             aclk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_null,
  input  logic [VAL_W-1:0] in_value,
  output logic             in_ready,
  output logic             grst,
  output logic             y,
  output logic [VAL_W-1:0] gamma_cnt
);

  localparam int unsigned      CMP_W         = 32;
  localparam logic [VAL_W-1:0] LAST_SLOT     = VAL_W'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [VAL_W-1:0] MAX_SPIKE_VAL = VAL_W'(GAMMA_CYCLE_WIDTH - 2);

  logic [VAL_W-1:0] gcnt;
  logic             pend_valid;
  logic             pend_null;
  logic [VAL_W-1:0] pend_val;
  logic             act_valid;
  logic [VAL_W-1:0] act_val;

  logic             boundary;
  logic             xfer;
  logic [CMP_W-1:0] slot_w;
  logic [CMP_W-1:0] lo_w;
  logic [CMP_W-1:0] hi_w;

  // A value produces a spike only if its first spike slot still fits in the gamma
  function automatic logic will_spike(input logic is_null, input logic [VAL_W-1:0] val);
    return !is_null && (val <= MAX_SPIKE_VAL);
  endfunction

  always_comb begin
    boundary = (gcnt == LAST_SLOT);
    xfer     = in_valid && !pend_valid;
  end

  // Gamma counter, pending slot and the value being emitted this gamma
  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      gcnt       <= '0;
      pend_valid <= 1'b0;
      pend_null  <= 1'b0;
      pend_val   <= '0;
      act_valid  <= 1'b0;
      act_val    <= '0;
    end else begin
      gcnt <= boundary ? '0 : gcnt + VAL_W'(1);
      if (boundary) begin
        if (pend_valid) begin
          act_valid  <= will_spike(pend_null, pend_val);
          act_val    <= pend_val;
          pend_valid <= 1'b0;
        end else if (xfer) begin
          act_valid <= will_spike(in_null, in_value);
          act_val   <= in_value;
        end else begin
          act_valid <= 1'b0;
        end
      end else if (xfer) begin
        pend_valid <= 1'b1;
        pend_null  <= in_null;
        pend_val   <= in_value;
      end
    end
  end

  // Spike window [act_val+1, act_val+PULSE_WIDTH], compared wide to avoid overflow
  always_comb begin
    slot_w    = CMP_W'(gcnt);
    lo_w      = CMP_W'(act_val) + CMP_W'(1);
    hi_w      = CMP_W'(act_val) + CMP_W'(PULSE_WIDTH);
    y         = act_valid && (slot_w >= lo_w) && (slot_w <= hi_w);
    grst      = (gcnt == '0);
    in_ready  = !pend_valid;
    gamma_cnt = gcnt;
  end

endmodule
